// File: rtl/cmos_pkg.sv
// ---------------------------------------------------------------------------
// cmos_pkg
//
// Definitions shared by the DVP pixel-capture stage.
//   cap_state_t : capture FSM states
//                   WAIT_INIT - waiting for camera register init to finish
//                   SKIP      - discarding settling frames
//                   WAIT_VS   - armed, waiting for the next frame to begin
//                   ACTIVE    - capturing the current frame
//   COORD_W     : width of the pixel x/y coordinate buses
// ---------------------------------------------------------------------------
package cmos_pkg;

    localparam int COORD_W = 12;

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        SKIP      = 2'd1,
        WAIT_VS   = 2'd2,
        ACTIVE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/dvp_byte_packer.sv
// ---------------------------------------------------------------------------
// dvp_byte_packer
//
// Packs consecutive DVP bytes into 16-bit RGB565 pixels. The first byte of a
// pair becomes the high byte. A pixel is only emitted when the caller marks
// it as acceptable; rejected pixels still consume their byte pair.
//
// Ports:
//   clk        in   camera pixel clock
//   rst        in   asynchronous active-high reset
//   clear      in   forces the byte phase back to 0 (line end / not capturing)
//   byte_en    in   a valid DVP byte is present on data this cycle
//   accept     in   the pixel completed this cycle may be emitted
//   data       in   registered DVP byte
//   phase      out  0 = next byte is a high byte, 1 = next byte completes a pixel
//   pix_data   out  RGB565 pixel, first byte in [15:8]
//   pix_valid  out  one-cycle strobe per emitted pixel
// ---------------------------------------------------------------------------
module dvp_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic        phase,
    output logic [15:0] pix_data,
    output logic        pix_valid
);

    logic [7:0] hi_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= 1'b0;
            hi_byte   <= 8'h00;
            pix_data  <= 16'h0000;
            pix_valid <= 1'b0;
        end else begin
            // Strobe defaults low and is only raised on the completing byte.
            pix_valid <= 1'b0;
            if (clear) begin
                phase <= 1'b0;
            end else if (byte_en) begin
                phase <= ~phase;
                if (!phase) begin
                    hi_byte <= data;
                end else if (accept) begin
                    pix_data  <= {hi_byte, data};
                    pix_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cmos_capture.sv
// ---------------------------------------------------------------------------
// cmos_capture
//
// DVP pixel-capture stage. After init_done it discards SKIP_FRAMES whole
// frames, then captures each frame from the camera's VSYNC/HREF/D[7:0] bus,
// packing byte pairs into RGB565 pixels tagged with x/y coordinates.
//
// Parameters:
//   H_ACTIVE     pixels per line
//   V_ACTIVE     lines per frame
//   SKIP_FRAMES  complete frames discarded after init_done rises (0 allowed)
//
// Ports:
//   clk          in   camera PCLK, all logic on rising edge
//   rst          in   asynchronous active-high reset
//   init_done    in   camera init finished (already synchronous to clk)
//   cam_vsync    in   vertical sync, high = blanking
//   cam_href     in   high during active line bytes
//   cam_data     in   DVP byte
//   pix_data     out  RGB565 pixel, first byte of pair in [15:8]
//   pix_valid    out  one-cycle strobe per pixel
//   pix_x        out  column of pix_data
//   pix_y        out  row of pix_data
//   frame_start  out  one-cycle pulse when a captured frame begins
//   frame_end    out  one-cycle pulse when a captured frame ends
//   line_err     out  sticky line-format error, cleared at frame_start
//   frame_cnt    out  captured frame count, wraps
//   capturing    out  high while in the ACTIVE state
// ---------------------------------------------------------------------------
module cmos_capture
    import cmos_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init_done,
    input  logic               cam_vsync,
    input  logic               cam_href,
    input  logic [7:0]         cam_data,
    output logic [15:0]        pix_data,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               frame_start,
    output logic               frame_end,
    output logic               line_err,
    output logic [7:0]         frame_cnt,
    output logic               capturing
);

    localparam logic [COORD_W-1:0] H_LIM    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_LIM    = COORD_W'(V_ACTIVE);
    localparam logic [15:0]        SKIP_LIM = 16'(SKIP_FRAMES);

    // -----------------------------------------------------------------------
    // Input registers and edge detection
    // -----------------------------------------------------------------------
    logic       vs_r, hr_r, vs_d, hr_d;
    logic [7:0] d_r;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its source; blocking here would let vs_d
    // see the new vs_r and the edge detectors would never fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_r <= 1'b0;
            hr_r <= 1'b0;
            d_r  <= 8'h00;
            vs_d <= 1'b0;
            hr_d <= 1'b0;
        end else begin
            vs_r <= cam_vsync;
            hr_r <= cam_href;
            d_r  <= cam_data;
            vs_d <= vs_r;
            hr_d <= hr_r;
        end
    end

    logic vs_fall, vs_rise, hr_fall;

    assign vs_fall = vs_d & ~vs_r;
    assign vs_rise = ~vs_d & vs_r;
    assign hr_fall = hr_d & ~hr_r;

    // -----------------------------------------------------------------------
    // Capture qualifiers
    // -----------------------------------------------------------------------
    cap_state_t         state;
    logic               run;
    logic               byte_en;
    logic               line_end;
    logic               pix_try;
    logic               in_range;
    logic               frame_open;
    logic               phase;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [15:0]        skip_cnt;
    logic               seen_fall;

    // Dropping init_done stops capture at the very edge it is seen.
    assign run = init_done && (state == ACTIVE);

    // HREF during VSYNC blanking is ignored. Inside ACTIVE the only cycle with
    // vs_r high is the vs_rise cycle, and a byte landing there still belongs
    // to the frame, so only a settled-high VSYNC (vs_r & vs_d) masks HREF.
    assign byte_en    = run && hr_r && !(vs_r && vs_d);
    assign line_end   = run && hr_fall;
    assign pix_try    = byte_en && phase;
    assign in_range   = (x < H_LIM) && (y < V_LIM);
    assign frame_open = init_done && (state == WAIT_VS) && vs_fall;

    // -----------------------------------------------------------------------
    // Byte packer
    // -----------------------------------------------------------------------
    dvp_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (!run || line_end),
        .byte_en   (byte_en),
        .accept    (in_range),
        .data      (d_r),
        .phase     (phase),
        .pix_data  (pix_data),
        .pix_valid (pix_valid)
    );

    // -----------------------------------------------------------------------
    // Frame FSM with registered pulses and frame counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_INIT;
            skip_cnt    <= 16'd0;
            seen_fall   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_cnt   <= 8'd0;
            capturing   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            if (!init_done) begin
                // Abort from any state; an interrupted frame gets no frame_end.
                state     <= WAIT_INIT;
                skip_cnt  <= 16'd0;
                seen_fall <= 1'b0;
                capturing <= 1'b0;
            end else begin
                case (state)
                    WAIT_INIT: begin
                        skip_cnt  <= 16'd0;
                        seen_fall <= 1'b0;
                        state     <= (SKIP_FRAMES > 0) ? SKIP : WAIT_VS;
                    end
                    SKIP: begin
                        // A rise is counted only once a fall has been seen, so
                        // the partial frame in progress at init is not counted.
                        if (vs_fall) begin
                            seen_fall <= 1'b1;
                        end
                        if (vs_rise && seen_fall) begin
                            skip_cnt <= skip_cnt + 16'd1;
                            if (skip_cnt + 16'd1 == SKIP_LIM) begin
                                state <= WAIT_VS;
                            end
                        end
                    end
                    WAIT_VS: begin
                        if (vs_fall) begin
                            state       <= ACTIVE;
                            frame_start <= 1'b1;
                            capturing   <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (vs_rise) begin
                            state     <= WAIT_VS;
                            frame_end <= 1'b1;
                            capturing <= 1'b0;
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state     <= WAIT_INIT;
                        capturing <= 1'b0;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Coordinates and line error tracking
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            pix_x    <= '0;
            pix_y    <= '0;
            line_err <= 1'b0;
        end else if (frame_open) begin
            x        <= '0;
            y        <= '0;
            line_err <= 1'b0;
        end else if (line_end) begin
            // x saturates at H_LIM (overlong lines drop pixels), so x != 0
            // means the line produced at least one pixel.
            x <= '0;
            if (x != '0) begin
                y <= y + COORD_W'(1);
            end
            if (phase || (x != H_LIM)) begin
                line_err <= 1'b1;
            end
        end else if (pix_try) begin
            if (in_range) begin
                pix_x <= x;
                pix_y <= y;
                x     <= x + COORD_W'(1);
            end else begin
                line_err <= 1'b1;
            end
        end
    end

endmodule
